// File: rtl/audio_pkg.sv
// Shared types and constants for the audio stream arbiter.
// Register map, CTRL/STATUS bit positions and the CTRL bundle.
package audio_pkg;

  localparam int DATA_SIZE = 28;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_THRESH = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int CTRL_EN0    = 0;
  localparam int CTRL_EN1    = 1;
  localparam int CTRL_MODE   = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int ST_IRQ  = 0;
  localparam int ST_LAST = 1;
  localparam int ST_FULL = 2;

  typedef struct packed {
    logic irq_en;
    logic mode;
    logic en1;
    logic en0;
  } ctrl_t;

endpackage

// File: rtl/stream_out_reg.sv
// One-entry registered output stage for the arbitrated sample stream.
// A load always wins over a drain, giving full throughput.
module stream_out_reg #(
  parameter int DW = audio_pkg::DATA_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          chan_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          chan_o
);

  logic          full_q, full_d;
  logic [DW-1:0] data_q, data_d;
  logic          chan_q, chan_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    chan_d = chan_q;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
      chan_d = chan_i;
    end else if (ready_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      chan_q <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      chan_q <= chan_d;
    end
  end

  assign valid_o = full_q;
  assign data_o  = data_q;
  assign chan_o  = chan_q;

endmodule

// File: rtl/audio_stream_arbiter.sv
// Two-producer sample arbiter feeding driver_interface, with a
// sample counter, threshold interrupt and Avalon-MM register file.
module audio_stream_arbiter #(
  parameter int DATA_SIZE = audio_pkg::DATA_SIZE,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chipselect,
  input  logic [1:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  output logic [31:0]          read_data,
  output logic                 irq,
  input  logic                 sink0_valid,
  input  logic [DATA_SIZE-1:0] sink0_data,
  output logic                 sink0_ready,
  input  logic                 sink1_valid,
  input  logic [DATA_SIZE-1:0] sink1_data,
  output logic                 sink1_ready,
  output logic                 source_valid,
  output logic [DATA_SIZE-1:0] source_data,
  output logic                 source_channel,
  input  logic                 source_ready
);

  import audio_pkg::*;

  ctrl_t            ctrl_q, ctrl_d;
  logic             irq_pend_q, irq_pend_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      rdata_q, rdata_d;

  logic req0, req1, gnt0, gnt1;
  logic out_full, load_ok, sink_hs, src_hs;
  logic wr, rd, irq_set;
  logic [CNT_W-1:0] count_inc;
  logic [DATA_SIZE-1:0] win_data;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:CNT_W];

  assign req0 = sink0_valid & ctrl_q.en0;
  assign req1 = sink1_valid & ctrl_q.en1;

  // On a tie round-robin picks the channel that did not win last.
  assign gnt0 = req0 & (~req1 | ctrl_q.mode | last_grant_q);
  assign gnt1 = req1 & (~req0 | (~ctrl_q.mode & ~last_grant_q));

  assign load_ok     = ~out_full | source_ready;
  assign sink0_ready = gnt0 & load_ok;
  assign sink1_ready = gnt1 & load_ok;
  assign sink_hs     = sink0_ready | sink1_ready;
  assign src_hs      = out_full & source_ready;
  assign win_data    = gnt1 ? sink1_data : sink0_data;

  stream_out_reg #(
    .DW(DATA_SIZE)
  ) u_out (
    .clk    (clk),
    .rst    (rst),
    .load_i (sink_hs),
    .data_i (win_data),
    .chan_i (gnt1),
    .ready_i(source_ready),
    .valid_o(out_full),
    .data_o (source_data),
    .chan_o (source_channel)
  );

  assign source_valid = out_full;

  assign wr        = chipselect & write;
  assign rd        = chipselect & read;
  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    ctrl_d       = ctrl_q;
    irq_pend_d   = irq_pend_q;
    last_grant_d = last_grant_q;
    thresh_d     = thresh_q;
    count_d      = count_q;
    rdata_d      = '0;
    irq_set      = 1'b0;

    if (sink_hs) last_grant_d = gnt1;
    if (wr && address == REG_CTRL) ctrl_d = ctrl_t'(writedata[3:0]);
    if (wr && address == REG_THRESH) thresh_d = writedata[CNT_W-1:0];

    // A software clear beats a same-cycle increment and its irq.
    if (wr && address == REG_COUNT) begin
      count_d = '0;
    end else if (src_hs) begin
      if (thresh_q != '0 && count_inc == thresh_q) begin
        count_d = '0;
        irq_set = 1'b1;
      end else begin
        count_d = count_inc;
      end
    end

    if (irq_set)
      irq_pend_d = 1'b1;
    else if (wr && address == REG_STATUS && writedata[ST_IRQ])
      irq_pend_d = 1'b0;

    if (rd) begin
      case (address)
        REG_CTRL:   rdata_d = {28'd0, ctrl_q};
        REG_STATUS: begin
          rdata_d[ST_IRQ]  = irq_pend_q;
          rdata_d[ST_LAST] = last_grant_q;
          rdata_d[ST_FULL] = out_full;
        end
        REG_THRESH: rdata_d = 32'(thresh_q);
        default:    rdata_d = 32'(count_q);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q       <= '0;
      irq_pend_q   <= 1'b0;
      last_grant_q <= 1'b1;
      thresh_q     <= '0;
      count_q      <= '0;
      rdata_q      <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      irq_pend_q   <= irq_pend_d;
      last_grant_q <= last_grant_d;
      thresh_q     <= thresh_d;
      count_q      <= count_d;
      rdata_q      <= rdata_d;
    end
  end

  assign read_data = rdata_q;
  assign irq       = irq_pend_q & ctrl_q.irq_en;

endmodule

// File: tb/tb_audio_stream_arbiter.sv
// Scoreboard bench for audio_stream_arbiter: directed stimulus pushes
// expected samples; a negedge monitor pops them on source handshakes.
module tb_audio_stream_arbiter;

  localparam logic [27:0] A = 28'hA000000;
  localparam logic [27:0] B = 28'hB000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        chipselect, read, write;
  logic [1:0]  address;
  logic [31:0] writedata, read_data;
  logic        irq;
  logic        sink0_valid, sink1_valid, sink0_ready, sink1_ready;
  logic [27:0] sink0_data, sink1_data, source_data;
  logic        source_valid, source_channel, source_ready;

  int checks = 0;
  int errors = 0;
  logic [28:0] exp_q[$];
  logic [27:0] k0 = '0;
  logic [27:0] k1 = '0;
  logic        r0, r1;

  always #5 clk = ~clk;

  audio_stream_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .chipselect    (chipselect),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .read_data     (read_data),
    .irq           (irq),
    .sink0_valid   (sink0_valid),
    .sink0_data    (sink0_data),
    .sink0_ready   (sink0_ready),
    .sink1_valid   (sink1_valid),
    .sink1_data    (sink1_data),
    .sink1_ready   (sink1_ready),
    .source_valid  (source_valid),
    .source_data   (source_data),
    .source_channel(source_channel),
    .source_ready  (source_ready)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && source_valid && source_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got ch%0d %h expected none",
                 source_channel, source_data);
      end else begin
        chk("sb_sample", {3'd0, source_channel, source_data},
            {3'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push(input logic ch, input logic [27:0] d);
    exp_q.push_back({ch, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sink0_data = A + k0;
    sink1_data = B + k1;
    #1;
    r0 = sink0_ready;
    r1 = sink1_ready;
    if (r0) k0++;
    if (r1) k1++;
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [1:0] a,
                       input logic [31:0] exp);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
    chk(name, read_data, exp);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_valid"}, {31'd0, source_valid}, 32'd0);
    chk({name, "_data"}, {4'd0, source_data}, 32'd0);
    chk({name, "_chan"}, {31'd0, source_channel}, 32'd0);
    chk({name, "_rdata"}, read_data, 32'd0);
    chk({name, "_irq"}, {31'd0, irq}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    chipselect = 0; read = 0; write = 0; address = 0; writedata = 0;
    sink0_valid = 0; sink1_valid = 0; sink0_data = 0; sink1_data = 0;
    source_ready = 0;
    repeat (2) tick();
    chk_reset_outs("reset");
    rst = 1'b0;
    tick();
    rdchk("rst_status", 2'd1, 32'h2);

    // single sample from ch0
    wr(2'd0, 32'h1);
    source_ready = 1'b1;
    push(1'b0, 28'h1234567);
    sink0_data = 28'h1234567;
    sink0_valid = 1'b1;
    #1;
    chk("first_ready", {31'd0, sink0_ready}, 32'd1);
    tick();
    sink0_valid = 1'b0;
    chk("first_valid", {31'd0, source_valid}, 32'd1);
    tick();
    rdchk("first_count", 2'd3, 32'd1);

    // round-robin: last grant was ch0, so ch1 leads
    wr(2'd0, 32'h3);
    push(1'b1, B + 28'd0);
    push(1'b0, A + 28'd0);
    push(1'b1, B + 28'd1);
    push(1'b0, A + 28'd1);
    sink0_valid = 1'b1; sink1_valid = 1'b1;
    repeat (4) step();
    sink0_valid = 1'b0; sink1_valid = 1'b0;

    // fixed priority
    wr(2'd0, 32'h7);
    push(1'b0, A + 28'd2);
    push(1'b0, A + 28'd3);
    push(1'b0, A + 28'd4);
    sink0_valid = 1'b1; sink1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("prio_rdy1", {31'd0, r1}, 32'd0);
    end
    sink0_valid = 1'b0; sink1_valid = 1'b0;

    // backpressure
    wr(2'd0, 32'h3);
    push(1'b1, B + 28'd2);
    push(1'b0, A + 28'd5);
    source_ready = 1'b0;
    sink0_valid = 1'b1; sink1_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_rdy", {30'd0, r0, r1}, 32'd0);
      chk("stall_data", {4'd0, source_data}, {4'd0, B + 28'd2});
    end
    source_ready = 1'b1;
    step();
    sink0_valid = 1'b0; sink1_valid = 1'b0;
    step();
    chk("drained", {31'd0, source_valid}, 32'd0);

    // threshold interrupt
    wr(2'd3, 32'd0);
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h9);
    for (int i = 6; i < 10; i++) push(1'b0, A + 28'(i));
    sink0_valid = 1'b1;
    repeat (4) step();
    sink0_valid = 1'b0;
    step();
    chk("irq_set", {31'd0, irq}, 32'd1);
    rdchk("irq_count", 2'd3, 32'd0);
    rdchk("irq_status", 2'd1, 32'h1);
    wr(2'd1, 32'h1);
    chk("irq_w1c", {31'd0, irq}, 32'd0);

    // W1C coincident with the next threshold hit
    for (int i = 10; i < 14; i++) push(1'b0, A + 28'(i));
    sink0_valid = 1'b1;
    repeat (4) step();
    sink0_valid = 1'b0;
    chipselect = 1'b1; write = 1'b1; address = 2'd1; writedata = 32'h1;
    step();
    chipselect = 1'b0; write = 1'b0;
    chk("irq_set_wins", {31'd0, irq}, 32'd1);
    wr(2'd1, 32'h1);
    chk("irq_clear2", {31'd0, irq}, 32'd0);

    // COUNT clear coincident with an increment
    push(1'b0, A + 28'd14);
    sink0_valid = 1'b1;
    step();
    sink0_valid = 1'b0;
    chipselect = 1'b1; write = 1'b1; address = 2'd3; writedata = 32'h0;
    step();
    chipselect = 1'b0; write = 1'b0;
    rdchk("count_clr_wins", 2'd3, 32'd0);
    chk("count_clr_noirq", {31'd0, irq}, 32'd0);

    // disabled ch1 never ready
    sink1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dis_rdy1", {31'd0, r1}, 32'd0);
    end
    sink1_valid = 1'b0;

    // clearing en0 keeps the held sample
    push(1'b0, A + 28'd15);
    source_ready = 1'b0;
    sink0_valid = 1'b1;
    step();
    sink0_valid = 1'b0;
    wr(2'd0, 32'h0);
    rdchk("held_status", 2'd1, 32'h4);
    source_ready = 1'b1;
    step();
    chk("held_gone", {31'd0, source_valid}, 32'd0);

    // reset mid-stream: B+3 delivered, A+16 lost
    wr(2'd0, 32'h3);
    push(1'b1, B + 28'd3);
    sink0_valid = 1'b1; sink1_valid = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    chk_reset_outs("midrst");
    sink0_valid = 1'b0; sink1_valid = 1'b0;
    tick();
    rst = 1'b0;
    wr(2'd0, 32'h3);
    push(1'b0, A + 28'd17);
    push(1'b1, B + 28'd4);
    sink0_valid = 1'b1; sink1_valid = 1'b1;
    step();
    chk("rst_tie_ch0", {30'd0, r0, r1}, 32'h2);
    step();
    sink0_valid = 1'b0; sink1_valid = 1'b0;
    step();
    tick();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_stream_arbiter.md
# audio_stream_arbiter

Shares the single 28-bit audio sample stream into `driver_interface` between two upstream sample producers (e.g. synthesiser and playback DMA). Arbitrates between two Avalon-ST sinks, registers the winner into a one-entry output stage, and counts delivered samples. Software controls it through a small Avalon-MM register file and an interrupt when a programmed sample count has been delivered.

## Interface
Parameters:
- `DATA_SIZE`, 28, sample width on all streams.
- `CNT_W`, 16, width of the sample counter and threshold.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `chipselect`  in  1  Avalon-MM select.
- `address`  in  2  register index.
- `read`  in  1  read strobe.
- `write`  in  1  write strobe.
- `writedata`  in  32  write data.
- `read_data`  out  32  read data, registered.
- `irq`  out  1  level interrupt = `irq_pending & irq_en`.
- `sink0_valid`, `sink1_valid`  in  1  requester valid.
- `sink0_data`, `sink1_data`  in  DATA_SIZE  requester sample.
- `sink0_ready`, `sink1_ready`  out  1  requester accept.
- `source_valid`  out  1  sample to `driver_interface` valid.
- `source_data`  out  DATA_SIZE  sample.
- `source_channel`  out  1  index of the requester that produced `source_data`.
- `source_ready`  in  1  downstream accept.

## Operation
- Registers:
  - 0 CTRL (rw): b0 `en0`, b1 `en1`, b2 `mode` (0 = round-robin, 1 = fixed priority ch0), b3 `irq_en`.
  - 1 STATUS: b0 `irq_pending` (write 1 clears), b1 `last_grant` (ro), b2 `out_full` (ro).
  - 2 THRESH (rw, CNT_W bits).
  - 3 COUNT (ro; any write clears to 0).
  - Unused bits read 0.
- Request `reqN = sinkN_valid & enN`.
- Grant (combinational):
  - Single request wins.
  - Both requesting: mode 1 gives ch0; mode 0 gives the channel ≠ `last_grant`.
  - `last_grant` updates only on a sink handshake.
- Load condition `load = !out_full | source_ready`.
- `sinkN_ready = grantN & load`. A disabled channel always sees ready = 0.
- On a sink handshake the output register captures the data and channel, and sets `out_full`.
- On a source handshake with no new load, `out_full` clears.
- `source_valid = out_full`. Data is held stable while valid and not ready.
- COUNT increments on each source handshake.
  - If THRESH ≠ 0 and the incremented value equals THRESH: COUNT becomes 0 and `irq_pending` sets.
  - If THRESH = 0: COUNT wraps modulo 2^CNT_W and no irq is raised.
- Simultaneous events:
  - irq set and a W1C clear in the same cycle: set wins.
  - COUNT-clear write and increment in the same cycle: COUNT = 0, no irq.
- Clearing an enable mid-stream does not discard a sample already in the output register; it is still delivered.
- Reset values:
  - All registers 0.
  - `source_valid`, `source_data`, `source_channel`, `read_data`, `irq` = 0.
  - `last_grant` = 1, so ch0 wins the first round-robin tie.

## Timing
- Sink-to-source latency: 1 cycle. A sample accepted at edge n is valid after edge n.
- Full throughput is 1 sample/cycle while `source_ready` = 1.
- Read latency 1 cycle: `read_data` is valid the cycle after `chipselect & read` and is 0 in any cycle without a prior read.
- Writes take effect at the clock edge. A new CTRL value affects grant in the next cycle.
- `irq` asserts the cycle after the threshold handshake.
- Reset asserted mid-transfer clears everything immediately; the in-flight sample is lost.

## Structure
- Shared package `audio_pkg`:
  - `DATA_SIZE` default.
  - Register address constants `REG_CTRL/STATUS/THRESH/COUNT`.
  - CTRL/STATUS bit-index constants.
  - `ctrl_t` packed struct.
- Sub-module `stream_out_reg`: one-entry output stage (data, channel, valid) with `load`/`source_ready` handshake.
- Arbiter, counter and register file live in the top module.

## Test plan
- Reset, then `sink0_valid`=1, data 28'h1234567, `en0`=1, `source_ready`=1 → `source_valid` 1 cycle later with 28'h1234567, `source_channel`=0, COUNT=1.
- Both sinks valid continuously, mode 0, both enabled → `source_channel` alternates 0,1,0,1; mode 1 → all 0 and `sink1_ready` stays 0.
- `source_ready`=0 for 5 cycles with output full → `source_data` stable, both sink readies 0; release → next sample follows 1 cycle later with no loss or duplication.
- THRESH=4, `irq_en`=1, stream 4 samples → `irq`=1 after the 4th handshake, COUNT=0; write STATUS=1 → `irq`=0; W1C coincident with the next threshold hit leaves `irq`=1.
- `en1`=0 while `sink1_valid`=1 → `sink1_ready` never 1. Clear `en0` with a sample in the output register → that sample is still delivered.
- Assert `rst` mid-stream → all outputs 0 immediately; after release a tie grants ch0 first.
